// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader and the instruction
// memory itself: loader state encoding, memory sizing and byte-lane helpers.
package imem_pkg;

    localparam int IMEM_BYTES  = 65536;
    localparam int IMEM_ADDR_W = 16;
    localparam int WORD_LANES  = 4;

    // Byte enable of lane 0; shifting it by a lane index gives that lane's enable.
    localparam logic [WORD_LANES-1:0] LANE0_BE = 4'b0001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } load_state_t;

    function automatic logic [WORD_LANES-1:0] lane_be(input logic [1:0] lane);
        lane_be = LANE0_BE << lane;
    endfunction

endpackage

// File: rtl/imem_load_ctrl_if.sv
// Single read/write port of the byte-addressed instruction memory.
// The controller drives address, write data and strobes; the memory returns
// combinational read data for the presented address.
interface imem_load_ctrl_if;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_we;
    logic [31:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_be,
        output mem_we,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_be,
        input  mem_we,
        output mem_rdata
    );

endinterface

// File: rtl/imem_byte_packer.sv
// Packs an accepted byte stream little-endian into 32-bit words and produces
// one registered write per completed word (full word or final partial word).
// The pack register clears on the same edge the word is handed off, so a byte
// can be accepted on every cycle without a bubble.
module imem_byte_packer
    import imem_pkg::*;
#(
    parameter int ADDR_W    = IMEM_ADDR_W,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              accept,
    input  logic [7:0]        data_in,
    input  logic [ADDR_W:0]   len,
    output logic              last_byte,
    output logic              wr_we,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [3:0]        wr_be
);

    localparam logic [ADDR_W-1:0] WORD_MASK = ~(ADDR_W'(3));

    logic [ADDR_W:0]   count;
    logic [31:0]       pack;
    logic [3:0]        fill;
    logic [1:0]        lane;
    logic [31:0]       merged_data;
    logic [3:0]        merged_be;
    logic              word_done;
    logic [ADDR_W-1:0] word_addr;

    assign lane        = count[1:0];
    assign last_byte   = (count == (len - (ADDR_W+1)'(1)));
    assign merged_data = pack | ({24'h0, data_in} << {lane, 3'b000});
    assign merged_be   = fill | lane_be(lane);
    assign word_done   = (lane == 2'd3) || last_byte;
    assign word_addr   = ADDR_W'(BASE_ADDR) + (count[ADDR_W-1:0] & WORD_MASK);

    // Lane counter, pack register and the registered write toward the memory port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            pack    <= '0;
            fill    <= '0;
            wr_we   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_be   <= '0;
        end else begin
            wr_we <= 1'b0;
            wr_be <= '0;
            if (clear) begin
                count <= '0;
                pack  <= '0;
                fill  <= '0;
            end else if (accept) begin
                count <= count + (ADDR_W+1)'(1);
                if (word_done) begin
                    wr_we   <= 1'b1;
                    wr_data <= merged_data;
                    wr_be   <= merged_be;
                    wr_addr <= word_addr;
                    pack    <= '0;
                    fill    <= '0;
                end else begin
                    pack <= merged_data;
                    fill <= merged_be;
                end
            end
        end
    end

endmodule

// File: rtl/imem_load_ctrl.sv
// Owner of the instruction-memory port. In IDLE the fetch PC goes straight to
// the memory; during a load the core is stalled while a byte stream is packed
// into words and written upward from BASE_ADDR.
module imem_load_ctrl
    import imem_pkg::*;
#(
    parameter int ADDR_W    = IMEM_ADDR_W,
    parameter int MEM_BYTES = IMEM_BYTES,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              load_abort,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    input  logic [31:0]       fetch_pc,
    output logic              fetch_valid,
    output logic [31:0]       fetch_data,
    output logic              core_stall,
    imem_load_ctrl_if.master  mem,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err
);

    load_state_t       state;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W+1:0] end_addr;
    logic              len_ok;
    logic              accept;
    logic              last_byte;
    logic              pk_clear;
    logic              wr_we;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [3:0]        wr_be;

    // A load must be non-empty and must end inside the memory.
    assign end_addr = {1'b0, load_len} + (ADDR_W+2)'(BASE_ADDR);
    assign len_ok   = (load_len != '0) && (end_addr <= (ADDR_W+2)'(MEM_BYTES));

    // Abort takes priority over a pending byte, so that byte is never taken.
    assign s_ready  = (state == LOAD) && !load_abort;
    assign accept   = s_valid && s_ready;
    assign pk_clear = ((state == IDLE) && load_start && len_ok) ||
                      ((state == LOAD) && load_abort);

    assign fetch_valid   = (state == IDLE);
    assign fetch_data    = mem.mem_rdata;
    assign mem.mem_addr  = (state == IDLE) ? fetch_pc : {{(32-ADDR_W){1'b0}}, wr_addr};
    assign mem.mem_wdata = wr_data;
    assign mem.mem_be    = wr_be;
    assign mem.mem_we    = wr_we;

    imem_byte_packer #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR)
    ) u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (pk_clear),
        .accept    (accept),
        .data_in   (s_data),
        .len       (len_q),
        .last_byte (last_byte),
        .wr_we     (wr_we),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_be     (wr_be)
    );

    // Load sequencing with registered stall, busy and one-cycle done/err pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            len_q      <= '0;
            core_stall <= 1'b0;
            load_busy  <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            load_done <= 1'b0;
            load_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        if (len_ok) begin
                            state      <= LOAD;
                            len_q      <= load_len;
                            core_stall <= 1'b1;
                            load_busy  <= 1'b1;
                        end else begin
                            load_err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (load_abort) begin
                        state      <= IDLE;
                        core_stall <= 1'b0;
                        load_busy  <= 1'b0;
                        load_err   <= 1'b1;
                    end else if (accept && last_byte) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    state      <= IDLE;
                    core_stall <= 1'b0;
                    load_busy  <= 1'b0;
                    load_done  <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    core_stall <= 1'b0;
                    load_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl: table-driven idle-fetch and length-check
// vectors, plus hand-written multi-cycle load, abort and reset sequences.
module tb_imem_load_ctrl;
    import imem_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
    } fetch_vec_t;

    typedef struct {
        logic [16:0] len;
        logic        exp_err;
        logic        exp_busy;
    } len_vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start = 1'b0;
    logic [16:0] load_len = '0;
    logic        load_abort = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_ready;
    logic [31:0] fetch_pc = '0;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic        core_stall;
    logic        load_busy;
    logic        load_done;
    logic        load_err;

    int vec_count = 0;
    int miss_count = 0;
    wr_t wr_q[$];

    imem_load_ctrl_if bus();

    imem_load_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_start  (load_start),
        .load_len    (load_len),
        .load_abort  (load_abort),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .fetch_pc    (fetch_pc),
        .fetch_valid (fetch_valid),
        .fetch_data  (fetch_data),
        .core_stall  (core_stall),
        .mem         (bus),
        .load_busy   (load_busy),
        .load_done   (load_done),
        .load_err    (load_err)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Record every memory write mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (bus.mem_we)
            wr_q.push_back('{addr: bus.mem_addr, data: bus.mem_wdata, be: bus.mem_be});
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // One cycle: drive inputs at the falling edge, settle, then the caller samples.
    task automatic apply_stimulus(input logic start, input logic [16:0] len,
                                  input logic abort, input logic valid,
                                  input logic [7:0] data);
        @(negedge clk);
        load_start = start;
        load_len   = len;
        load_abort = abort;
        s_valid    = valid;
        s_data     = data;
        #1;
    endtask

    task automatic check_write(input string name, input int idx, input logic [31:0] addr,
                               input logic [31:0] data, input logic [31:0] data_mask,
                               input logic [3:0] be);
        check_output({name, " present"}, 32'(wr_q.size() > idx), 32'd1);
        if (wr_q.size() > idx) begin
            check_output({name, " addr"}, wr_q[idx].addr, addr);
            check_output({name, " data"}, wr_q[idx].data & data_mask, data);
            check_output({name, " be"}, {28'h0, wr_q[idx].be}, {28'h0, be});
        end
    endtask

    // Starts a load, streams nbytes (every cycle, or every other cycle when gap)
    // and reports timing relative to cycle 1, the first cycle a byte is offered.
    task automatic run_load(input logic [16:0] len, input logic [7:0] bytes[8],
                            input int nbytes, input bit gap, input int ncyc,
                            output int done_cyc, output int done_hits,
                            output int stall_bad, output int stall_at_done,
                            output int we_cyc);
        int  sent;
        logic valid;
        sent = 0;
        done_cyc = 0;
        done_hits = 0;
        stall_bad = 0;
        stall_at_done = -1;
        we_cyc = 0;
        apply_stimulus(1'b1, len, 1'b0, 1'b0, 8'h00);
        for (int c = 1; c <= ncyc; c++) begin
            valid = (sent < nbytes) && (!gap || (c % 2 == 1));
            apply_stimulus(1'b0, '0, 1'b0, valid, valid ? bytes[sent] : 8'h00);
            if (valid && s_ready)
                sent++;
            if (bus.mem_we && we_cyc == 0)
                we_cyc = c;
            if (load_done) begin
                done_hits++;
                if (done_cyc == 0) begin
                    done_cyc = c;
                    stall_at_done = int'(core_stall);
                end
            end
            if (done_cyc == 0 && !core_stall)
                stall_bad++;
        end
    endtask

    initial begin
        fetch_vec_t fv[4];
        len_vec_t   lv[5];
        logic [7:0] b_full[8];
        logic [7:0] b_tail[8];
        logic [7:0] b_gap[8];
        logic [7:0] b_new[8];
        int done_cyc, done_hits, stall_bad, stall_at_done, we_cyc;

        fv[0] = '{pc: 32'h0000_0008, rdata: 32'h00A0_0093, exp_addr: 32'h0000_0008, exp_data: 32'h00A0_0093};
        fv[1] = '{pc: 32'h0000_0000, rdata: 32'h0050_0113, exp_addr: 32'h0000_0000, exp_data: 32'h0050_0113};
        fv[2] = '{pc: 32'h0000_FFFC, rdata: 32'hDEAD_BEEF, exp_addr: 32'h0000_FFFC, exp_data: 32'hDEAD_BEEF};
        fv[3] = '{pc: 32'h1234_5670, rdata: 32'h0000_0013, exp_addr: 32'h1234_5670, exp_data: 32'h0000_0013};

        lv[0] = '{len: 17'd0,       exp_err: 1'b1, exp_busy: 1'b0};
        lv[1] = '{len: 17'd65537,   exp_err: 1'b1, exp_busy: 1'b0};
        lv[2] = '{len: 17'd1,       exp_err: 1'b0, exp_busy: 1'b1};
        lv[3] = '{len: 17'd65536,   exp_err: 1'b0, exp_busy: 1'b1};
        lv[4] = '{len: 17'h1FFFF,   exp_err: 1'b1, exp_busy: 1'b0};

        b_full = '{8'h93, 8'h00, 8'hA0, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00};
        b_tail = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h00, 8'h00};
        b_gap  = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h00, 8'h00, 8'h00, 8'h00};
        b_new  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};

        bus.mem_rdata = '0;

        // Reset values while rst_n is held low.
        #1;
        check_output("rst s_ready", 32'(s_ready), 32'd0);
        check_output("rst mem_we", 32'(bus.mem_we), 32'd0);
        check_output("rst mem_be", 32'(bus.mem_be), 32'd0);
        check_output("rst core_stall", 32'(core_stall), 32'd0);
        check_output("rst load_busy", 32'(load_busy), 32'd0);
        check_output("rst load_done", 32'(load_done), 32'd0);
        check_output("rst load_err", 32'(load_err), 32'd0);
        check_output("rst fetch_valid", 32'(fetch_valid), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle fetch pass-through.
        for (int i = 0; i < 4; i++) begin
            fetch_pc      = fv[i].pc;
            bus.mem_rdata = fv[i].rdata;
            apply_stimulus(1'b0, '0, 1'b0, 1'b0, 8'h00);
            check_output($sformatf("fetch%0d mem_addr", i), bus.mem_addr, fv[i].exp_addr);
            check_output($sformatf("fetch%0d fetch_data", i), fetch_data, fv[i].exp_data);
            check_output($sformatf("fetch%0d fetch_valid", i), 32'(fetch_valid), 32'd1);
            check_output($sformatf("fetch%0d mem_we", i), 32'(bus.mem_we), 32'd0);
        end

        // Length acceptance boundaries; accepted loads are aborted right away.
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b1, lv[i].len, 1'b0, 1'b0, 8'h00);
            apply_stimulus(1'b0, '0, 1'b0, 1'b0, 8'h00);
            check_output($sformatf("len%0d load_err", i), 32'(load_err), 32'(lv[i].exp_err));
            check_output($sformatf("len%0d load_busy", i), 32'(load_busy), 32'(lv[i].exp_busy));
            if (lv[i].exp_busy) begin
                apply_stimulus(1'b0, '0, 1'b1, 1'b0, 8'h00);
                check_output($sformatf("len%0d abort s_ready", i), 32'(s_ready), 32'd0);
                apply_stimulus(1'b0, '0, 1'b0, 1'b0, 8'h00);
                check_output($sformatf("len%0d abort err", i), 32'(load_err), 32'd1);
                check_output($sformatf("len%0d abort busy", i), 32'(load_busy), 32'd0);
            end else begin
                apply_stimulus(1'b0, '0, 1'b0, 1'b0, 8'h00);
                check_output($sformatf("len%0d err pulse end", i), 32'(load_err), 32'd0);
            end
        end

        // Full-word load, back-to-back bytes.
        wr_q.delete();
        run_load(17'd8, b_full, 8, 1'b0, 13, done_cyc, done_hits, stall_bad, stall_at_done, we_cyc);
        check_output("full done cycle", 32'(done_cyc), 32'd10);
        check_output("full done hits", 32'(done_hits), 32'd1);
        check_output("full stall gaps", 32'(stall_bad), 32'd0);
        check_output("full stall at done", 32'(stall_at_done), 32'd0);
        check_output("full write count", 32'(wr_q.size()), 32'd2);
        check_write("full wr0", 0, 32'h0, 32'h00A0_0093, 32'hFFFF_FFFF, 4'hF);
        check_write("full wr1", 1, 32'h4, 32'h0050_0113, 32'hFFFF_FFFF, 4'hF);

        // Partial tail word.
        wr_q.delete();
        run_load(17'd6, b_tail, 6, 1'b0, 10, done_cyc, done_hits, stall_bad, stall_at_done, we_cyc);
        check_output("tail done cycle", 32'(done_cyc), 32'd8);
        check_output("tail write count", 32'(wr_q.size()), 32'd2);
        check_write("tail wr0", 0, 32'h0, 32'h4433_2211, 32'hFFFF_FFFF, 4'hF);
        check_write("tail wr1", 1, 32'h4, 32'h0000_6655, 32'h0000_FFFF, 4'h3);

        // Stalled stream: one write, on the cycle after the fourth accept.
        wr_q.delete();
        run_load(17'd4, b_gap, 4, 1'b1, 12, done_cyc, done_hits, stall_bad, stall_at_done, we_cyc);
        check_output("gap first write cycle", 32'(we_cyc), 32'd8);
        check_output("gap write count", 32'(wr_q.size()), 32'd1);
        check_write("gap wr0", 0, 32'h0, 32'hD4C3_B2A1, 32'hFFFF_FFFF, 4'hF);
        check_output("gap done cycle", 32'(done_cyc), 32'd9);

        // Abort after 3 of 8 bytes.
        wr_q.delete();
        apply_stimulus(1'b1, 17'd8, 1'b0, 1'b0, 8'h00);
        for (int c = 0; c < 3; c++)
            apply_stimulus(1'b0, '0, 1'b0, 1'b1, b_full[c]);
        apply_stimulus(1'b0, '0, 1'b1, 1'b1, b_full[3]);
        check_output("abort s_ready", 32'(s_ready), 32'd0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, 8'h00);
        check_output("abort load_err", 32'(load_err), 32'd1);
        check_output("abort core_stall", 32'(core_stall), 32'd0);
        check_output("abort load_busy", 32'(load_busy), 32'd0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, 8'h00);
        check_output("abort err pulse end", 32'(load_err), 32'd0);
        check_output("abort write count", 32'(wr_q.size()), 32'd0);

        // Abort in the same cycle as the last byte: abort wins, no done.
        wr_q.delete();
        done_hits = 0;
        apply_stimulus(1'b1, 17'd4, 1'b0, 1'b0, 8'h00);
        for (int c = 0; c < 3; c++)
            apply_stimulus(1'b0, '0, 1'b0, 1'b1, b_gap[c]);
        apply_stimulus(1'b0, '0, 1'b1, 1'b1, b_gap[3]);
        check_output("abort-last s_ready", 32'(s_ready), 32'd0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, 8'h00);
        check_output("abort-last load_err", 32'(load_err), 32'd1);
        for (int c = 0; c < 4; c++) begin
            if (load_done)
                done_hits++;
            apply_stimulus(1'b0, '0, 1'b0, 1'b0, 8'h00);
        end
        check_output("abort-last done hits", 32'(done_hits), 32'd0);
        check_output("abort-last write count", 32'(wr_q.size()), 32'd0);

        // Reset in the middle of a load.
        fetch_pc      = 32'h0000_0040;
        bus.mem_rdata = 32'h0000_0013;
        apply_stimulus(1'b1, 17'd8, 1'b0, 1'b0, 8'h00);
        for (int c = 0; c < 5; c++)
            apply_stimulus(1'b0, '0, 1'b0, 1'b1, b_full[c]);
        apply_stimulus(1'b0, '0, 1'b0, 1'b1, b_full[5]);
        rst_n = 1'b0;
        #1;
        check_output("midrst s_ready", 32'(s_ready), 32'd0);
        check_output("midrst core_stall", 32'(core_stall), 32'd0);
        check_output("midrst load_busy", 32'(load_busy), 32'd0);
        check_output("midrst mem_we", 32'(bus.mem_we), 32'd0);
        check_output("midrst mem_be", 32'(bus.mem_be), 32'd0);
        check_output("midrst load_done", 32'(load_done), 32'd0);
        check_output("midrst load_err", 32'(load_err), 32'd0);
        check_output("midrst fetch_valid", 32'(fetch_valid), 32'd1);
        check_output("midrst mem_addr", bus.mem_addr, 32'h0000_0040);
        @(negedge clk);
        s_valid = 1'b0;
        rst_n   = 1'b1;
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, 8'h00);
        check_output("postrst fetch_data", fetch_data, 32'h0000_0013);
        check_output("postrst mem_addr", bus.mem_addr, 32'h0000_0040);
        wr_q.delete();
        run_load(17'd4, b_new, 4, 1'b0, 8, done_cyc, done_hits, stall_bad, stall_at_done, we_cyc);
        check_output("postrst done cycle", 32'(done_cyc), 32'd6);
        check_output("postrst write count", 32'(wr_q.size()), 32'd1);
        check_write("postrst wr0", 0, 32'h0, 32'h0403_0201, 32'hFFFF_FFFF, 4'hF);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule

// File: doc/imem_load_ctrl.md
Name: imem_load_ctrl

Overview:
Controller that owns the single port of the byte-addressed instruction memory. It shares that port between the pipeline fetch stage and a program loader.
- Idle: the fetch PC passes straight to the memory.
- Load: the block accepts a byte stream, packs it little-endian into 32-bit words, writes them from BASE_ADDR upward and holds the core stalled until the image is complete.

Parameters:
ADDR_W, 16, byte-address width of instruction memory
MEM_BYTES, 65536, memory size in bytes; upper bound for load_len
BASE_ADDR, 0, byte address of first loaded byte (word aligned)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
load_start  in  1  one-cycle pulse, starts a load
load_len  in  ADDR_W+1  image length in bytes, sampled with load_start
load_abort  in  1  cancels an active load
s_valid  in  1  loader byte valid
s_data  in  8  loader byte
s_ready  out  1  byte accepted when s_valid && s_ready
fetch_pc  in  32  fetch-stage program counter
fetch_valid  out  1  fetch_data is a usable instruction
fetch_data  out  32  instruction to fetch stage
core_stall  out  1  holds PC and pipeline
mem_addr  out  32  memory byte address
mem_wdata  out  32  write word, little-endian
mem_be  out  4  byte enables; lane i = mem_wdata[8i+7:8i]
mem_we  out  1  write strobe, written at clk edge
mem_rdata  in  32  combinational read data at mem_addr
load_busy  out  1  state != IDLE
load_done  out  1  one-cycle pulse, load complete
load_err  out  1  one-cycle pulse, bad length or abort

Behaviour:
- Reset (async, rst_n=0) clears:
  - state=IDLE; byte counter, pack register, write registers = 0.
  - s_ready=0, mem_we=0, mem_be=0, core_stall=0, load_busy=0, load_done=0, load_err=0.
- States and transitions:
  - IDLE: mem_addr=fetch_pc, mem_we=0, fetch_data=mem_rdata, fetch_valid=1, s_ready=0.
  - IDLE, load_start with 1<=load_len<=MEM_BYTES -> LOAD; count=0, pack cleared.
  - IDLE, load_start with load_len=0 or >MEM_BYTES -> load_err pulse next cycle; stay IDLE.
  - LOAD: core_stall=1, fetch_valid=0, s_ready=!load_abort. mem_addr is the registered write address.
  - On each accept: byte goes to pack lane count[1:0]; count++.
  - Lane 3 or last byte (count==load_len-1) completes a word. Next cycle: mem_we=1, mem_wdata=pack incl. this byte, mem_be=lanes filled, mem_addr=BASE_ADDR+(count&~3). Pack clears the same edge, so there is no bubble and back-to-back bytes are accepted every cycle.
  - Last byte accepted -> FLUSH.
  - FLUSH: one cycle; the final write is on the port; s_ready=0, core_stall=1. -> IDLE with load_done pulse on the following cycle. core_stall drops in that same cycle.
  - load_start while load_busy=1 is ignored.
- Abort:
  - load_abort in LOAD -> IDLE next cycle with load_err pulse.
  - Partial pack is discarded, never written; already-written words remain.
  - Abort in the same cycle as the last byte: abort wins, byte not accepted (s_ready=0), no done.
  - Abort in FLUSH is ignored; the final write completes.
- Addressing: writes are word aligned, so the low 2 bits of mem_addr are 0 in LOAD/FLUSH. Address arithmetic is ADDR_W bits, zero-extended to 32; wrap cannot occur because load_len<=MEM_BYTES with BASE_ADDR=0. If BASE_ADDR+load_len>MEM_BYTES, that load_start takes the load_err path.
- Latency:
  - Fetch is combinational, zero cycles.
  - A load of N bytes presented every cycle reaches load_done at N+2 cycles after the first accept.
- Reset mid-load: immediate return to IDLE, stall released, no done/err pulse; memory contents undefined beyond already-written words.

Decomposition:
- Shared package imem_pkg:
  - state encoding (IDLE=2'd0, LOAD=2'd1, FLUSH=2'd2)
  - IMEM_BYTES and IMEM_ADDR_W constants, also used by instruction memory sizing
  - word-lane helper constant for byte-enable generation
- One natural sub-module, imem_byte_packer: lane counter, pack register, byte-enable/flush generation. The FSM and port mux stay in the top.

Test Plan:
- Idle fetch: fetch_pc=0x8, mem_rdata=0x00A00093 -> fetch_valid=1, fetch_data=0x00A00093, mem_addr=0x8, mem_we=0.
- Full-word load: load_len=8, bytes 93 00 A0 00 13 01 50 00 back-to-back. Required response:
  - writes {addr 0x0, 0x00A00093, be 4'hF} then {addr 0x4, 0x00500113, be 4'hF}
  - core_stall=1 throughout
  - load_done exactly 10 cycles after the first accept
- Partial tail: load_len=6, bytes 11 22 33 44 55 66 -> second write {addr 0x4, wdata[15:0]=0x6655, be 4'h3}.
- Stalled stream: s_valid toggles 1/0 for load_len=4 -> a single write on the cycle after the 4th accept; no write before.
- Errors:
  - load_len=0 -> load_err pulse, load_busy=0.
  - load_len=65537 -> load_err pulse, load_busy=0.
  - Abort after 3 of 8 bytes -> load_err pulse, no mem_we, stall released next cycle.
- Reset mid-load: rst_n low after 5 of 8 bytes -> all outputs at reset values asynchronously. After rst_n rises, fetch passes fetch_pc and a new load_start is accepted.
